// File: rtl/apu_tri_reg_sequencer_if.sv
// Command handshake between a requester and the triangle register sequencer.
interface apu_tri_reg_sequencer_if;
    logic       cmd_valid;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_addr, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_addr, input cmd_data, output cmd_ready);
endinterface

// File: rtl/apu_tri_reg_sequencer.sv
// Queues triangle-channel register writes and replays them as timed one-hot
// write strobes with the data driven on the core bus.
module apu_tri_reg_sequencer #(
    parameter int unsigned STROBE_LEN = 6,
    parameter int unsigned GAP_LEN    = 6,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      CLK,
    input  logic                      n_RES,
    input  logic                      PHI1,
    apu_tri_reg_sequencer_if.slave    cmd,
    output logic                      W4008,
    output logic                      W400A,
    output logic                      W400B,
    output logic                      W4015,
    output logic [7:0]                DB_out,
    output logic                      DB_oe,
    output logic                      busy,
    output logic [3:0]                count
);

    localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  STROBE_INIT = (STROBE_LEN == 0) ? 4'd0 : 4'(STROBE_LEN - 1);
    localparam logic [3:0]  GAP_INIT    = (GAP_LEN == 0) ? 4'd0 : 4'(GAP_LEN - 1);
    localparam logic [3:0]  DEPTH_W     = 4'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    tmr;
    logic [1:0]    iaddr;
    logic [7:0]    idata;
    logic [3:0]    stb;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          ready_q;
    logic [3:0]    count_nxt;
    logic          push;
    logic          pop;
    cmd_t          head;

    assign push          = cmd.cmd_valid & ready_q;
    assign pop           = (state == IDLE) && (count != 4'd0);
    assign head          = mem[rptr];
    assign cmd.cmd_ready = ready_q;

    // Occupancy after this edge; a push and a pop together cancel out.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 4'd1;
            2'b01:   count_nxt = count - 4'd1;
            default: count_nxt = count;
        endcase
    end

    // FIFO storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr] <= cmd_t'({cmd.cmd_addr, cmd.cmd_data});
        end
    end

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= 4'd0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                wptr <= (wptr == LAST_PTR) ? '0 : wptr + AW'(1);
            end
            if (pop) begin
                rptr <= (rptr == LAST_PTR) ? '0 : rptr + AW'(1);
            end
            count   <= count_nxt;
            ready_q <= (count_nxt < DEPTH_W);
        end
    end

    // Issue FSM; strobes, bus data and busy are registered from the next state.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            state  <= IDLE;
            tmr    <= 4'd0;
            iaddr  <= 2'd0;
            idata  <= 8'h00;
            stb    <= 4'd0;
            DB_out <= 8'h00;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != 4'd0) begin
                        state  <= STROBE;
                        tmr    <= STROBE_INIT;
                        iaddr  <= head.addr;
                        idata  <= head.data;
                        stb    <= 4'b0001 << head.addr;
                        DB_out <= head.data;
                        busy   <= 1'b1;
                    end else begin
                        stb    <= 4'd0;
                        DB_out <= 8'h00;
                        busy   <= (count_nxt != 4'd0);
                    end
                end
                STROBE: begin
                    if (tmr == 4'd0) begin
                        stb    <= 4'd0;
                        DB_out <= 8'h00;
                        if (GAP_LEN == 0) begin
                            state <= IDLE;
                            tmr   <= 4'd0;
                            busy  <= (count_nxt != 4'd0);
                        end else begin
                            state <= GAP;
                            tmr   <= GAP_INIT;
                            busy  <= 1'b1;
                        end
                    end else begin
                        tmr    <= tmr - 4'd1;
                        stb    <= 4'b0001 << iaddr;
                        DB_out <= idata;
                        busy   <= 1'b1;
                    end
                end
                GAP: begin
                    stb    <= 4'd0;
                    DB_out <= 8'h00;
                    if (tmr == 4'd0) begin
                        state <= IDLE;
                        busy  <= (count_nxt != 4'd0);
                    end else begin
                        tmr   <= tmr - 4'd1;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tmr    <= 4'd0;
                    stb    <= 4'd0;
                    DB_out <= 8'h00;
                    busy   <= (count_nxt != 4'd0);
                end
            endcase
        end
    end

    // Bus drive follows the core phase, so it is the one combinational output.
    assign DB_oe = (state == STROBE) & ~PHI1;

    assign W4008 = stb[0];
    assign W400A = stb[1];
    assign W400B = stb[2];
    assign W4015 = stb[3];

    a_stb_onehot: assert property (@(posedge CLK) disable iff (!n_RES) $onehot0(stb));
    a_count_max:  assert property (@(posedge CLK) disable iff (!n_RES) count <= DEPTH_W);

endmodule
